stopwatch_mode_ctrl: RTL and testbench

- Mode controller that sequences the MM:SS time counter.
- Cleans two raw push-buttons (start/pause, clear) and runs an IDLE/RUN/PAUSE/CLEAR state machine.
- Generates a single-clock-domain 1 Hz count-enable pulse, a counter-clear pulse and a heartbeat LED.
- Sits between board buttons and the counter/display path; the downstream counter runs on clk and uses tick_1hz as its enable. There is no derived clock.

---
 rtl/stopwatch_mode_ctrl.sv | 136 +++++++++++++
 tb/tb_stopwatch_mode_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mode_ctrl.sv
// rtl/stopwatch_mode_ctrl.sv - stopwatch mode FSM, button conditioning, 1 Hz count enable and heartbeat
// Optional lap/display-hold feature enabled by defining LAP_HOLD_EN.
module stopwatch_mode_ctrl #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clear,
`ifdef LAP_HOLD_EN
   input  logic       btn_lap,
   output logic       disp_hold,
`endif
   output logic       tick_1hz,
   output logic       cnt_clr,
   output logic [1:0] state,
   output logic       led
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
`ifdef LAP_HOLD_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      CLEAR = 2'b11
   } mode_t;

   mode_t         cur;
   mode_t         nxt;
   logic [NB-1:0] raw;
   logic [NB-1:0] sync1;
   logic [NB-1:0] synced;
   logic [NB-1:0] stable;
   logic [NB-1:0] stable_d;
   logic [NB-1:0] press;
   logic [DW-1:0] db_cnt [NB];
   logic [PW-1:0] psc;
   logic          sp;
   logic          cp;

`ifdef LAP_HOLD_EN
   assign raw = {btn_lap, btn_clear, btn_start};
`else
   assign raw = {btn_clear, btn_start};
`endif

   // A level is accepted only after it has disagreed with the stable value for DEBOUNCE_CYCLES edges in a row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= '0;
         synced   <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= raw;
         synced   <= sync1;
         stable_d <= stable;
         for (int i = 0; i < NB; i++) begin
            if (synced[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= synced[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign press = stable & ~stable_d;
   assign sp    = press[0];
   assign cp    = press[1];

   always_comb begin
      nxt      = cur;
      tick_1hz = 1'b0;
      cnt_clr  = 1'b0;
      case (cur)
         IDLE:    if (cp) nxt = CLEAR; else if (sp) nxt = RUN;
         RUN: begin
            if (cp) nxt = CLEAR; else if (sp) nxt = PAUSE;
            tick_1hz = (psc == PSC_LAST);
         end
         PAUSE:   if (cp) nxt = CLEAR; else if (sp) nxt = RUN;
         default: begin
            nxt     = IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   // Resuming from PAUSE keeps the prescaler so a partial second is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur <= IDLE;
         psc <= '0;
         led <= 1'b0;
      end else begin
         cur <= nxt;
         led <= led ^ tick_1hz;
         if (cur == CLEAR || (cur == IDLE && nxt == RUN)) begin
            psc <= '0;
         end else if (cur == RUN) begin
            psc <= (psc == PSC_LAST) ? '0 : psc + PW'(1);
         end
      end
   end

   assign state = cur;

`ifdef LAP_HOLD_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_hold <= 1'b0;
      end else if (cur == CLEAR) begin
         disp_hold <= 1'b0;
      end else if (press[2]) begin
         if (cur == RUN) disp_hold <= ~disp_hold;
         else if (cur == PAUSE) disp_hold <= 1'b0;
      end
   end
`endif
endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// tb/tb_stopwatch_mode_ctrl.sv - self-checking bench for stopwatch_mode_ctrl (default build, LAP_HOLD_EN undefined)
module tb_stopwatch_mode_ctrl;
   localparam int CLK_HZ  = 10;
   localparam int TICK_HZ = 1;
   localparam int DEB     = 4;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic       clk;
   logic       rst;
   logic       btn_start;
   logic       btn_clear;
   logic       tick_1hz;
   logic       cnt_clr;
   logic [1:0] state;
   logic       led;

   int checks = 0;
   int errors = 0;
   int c;

   stopwatch_mode_ctrl #(
      .CLK_HZ(CLK_HZ),
      .TICK_HZ(TICK_HZ),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_start(btn_start),
      .btn_clear(btn_clear),
      .tick_1hz(tick_1hz),
      .cnt_clr(cnt_clr),
      .state(state),
      .led(led)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Number of clock edges since reset was last released.
   always @(posedge clk or negedge rst) begin
      if (!rst) c <= 0;
      else      c <= c + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, c, act, exp);
      end
   endtask

   task automatic goto(input int t);
      while (c < t) @(negedge clk);
   endtask

   // Reference model: raw sample history per button, mode as an integer, seconds phase as a modulo counter.
   bit hist [2][DEB+2];
   bit m_stable [2];
   bit m_pend [2];
   int m_mode;
   int m_phase;
   bit m_led;
   bit m_tk;
   bit m_flip;
   int m_old;
   bit m_raw [2];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < DEB + 2; k++) hist[b][k] = 1'b0;
            m_stable[b] = 1'b0;
            m_pend[b]   = 1'b0;
         end
         m_mode  = 0;
         m_phase = 0;
         m_led   = 1'b0;
      end else begin
         m_tk  = (m_mode == 1) && (m_phase == DIV - 1);
         m_old = m_mode;
         if (m_old == 3)        m_mode = 0;
         else if (m_pend[1])    m_mode = 3;
         else if (m_pend[0])    m_mode = (m_old == 1) ? 2 : 1;
         if (m_old == 1)                              m_phase = (m_phase + 1) % DIV;
         else if (m_old == 3 || (m_old == 0 && m_mode == 1)) m_phase = 0;
         if (m_tk) m_led = !m_led;
         m_raw[0] = btn_start;
         m_raw[1] = btn_clear;
         for (int b = 0; b < 2; b++) begin
            for (int k = DEB + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = m_raw[b];
            // stable flips once the samples taken 2..DEB+1 edges ago all disagree with it
            m_flip = 1'b1;
            for (int k = 2; k <= DEB + 1; k++) if (hist[b][k] == m_stable[b]) m_flip = 1'b0;
            m_pend[b] = 1'b0;
            if (m_flip) begin
               m_stable[b] = !m_stable[b];
               m_pend[b]   = m_stable[b];
            end
         end
      end
   end

   logic [4:0] m_exp;
   always @(negedge clk) begin
      m_exp = {2'(m_mode), (m_mode == 1) && (m_phase == DIV - 1), m_mode == 3, m_led};
      chk("model", int'({state, tick_1hz, cnt_clr, led}), int'(m_exp));
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   int hold_s;
   int hold_c;

   initial begin
      rst       = 1'b0;
      btn_start = 1'b0;
      btn_clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", state, 0);
      chk("reset_tick", tick_1hz, 0);
      chk("reset_clr", cnt_clr, 0);
      chk("reset_led", led, 0);
      rst = 1'b1;

      // short glitch: three sampled cycles, too short to be accepted
      goto(2);  btn_start = 1'b1;
      goto(5);  btn_start = 1'b0;
      goto(14); chk("glitch_state", state, 0);

      // start press, then ticks on RUN cycles 10/20/30, then a pause press launched at cycle 52
      goto(16); btn_start = 1'b1;
      for (int t = 17; t <= 57; t++) begin
         goto(t);
         chk("tick_run", tick_1hz, int'(t >= 23 && (t - 22) % 10 == 0));
         if (t == 22) chk("pre_run_state", state, 0);
         if (t == 23) chk("run_entry_state", state, 1);
         if (t == 33) chk("led_after_tick1", led, 1);
         if (t == 43) chk("led_after_tick2", led, 0);
         if (t == 53) chk("led_after_tick3", led, 1);
         if (t == 28) btn_start = 1'b0;
         if (t == 52) btn_start = 1'b1;
         if (t == 57) btn_start = 1'b0;
      end
      goto(58); chk("pre_pause_state", state, 1);
      goto(59); chk("pause_state", state, 2);
      for (int t = 59; t <= 78; t++) begin
         goto(t);
         chk("pause_tick", tick_1hz, 0);
         chk("pause_led", led, 1);
         if (t == 72) btn_start = 1'b1;
         if (t == 77) btn_start = 1'b0;
      end
      for (int t = 79; t <= 82; t++) begin
         goto(t);
         chk("resume_state", state, 1);
         chk("resume_tick", tick_1hz, int'(t == 82));
      end
      goto(83); chk("resume_led", led, 0);

      // simultaneous start and clear: clear wins
      goto(90); btn_start = 1'b1; btn_clear = 1'b1;
      goto(95); btn_start = 1'b0; btn_clear = 1'b0;
      goto(96); chk("both_pre_state", state, 1);
      goto(97); chk("clear_state", state, 3); chk("clear_pulse", cnt_clr, 1); chk("clear_led", led, 1);
      goto(98); chk("post_clear_state", state, 0); chk("post_clear_pulse", cnt_clr, 0);
      goto(99); chk("idle_hold_state", state, 0);

      // asynchronous reset mid-RUN with the prescaler at 7
      goto(104); btn_start = 1'b1;
      goto(109); btn_start = 1'b0;
      goto(111); chk("run2_state", state, 1);
      goto(118);
      #2 rst = 1'b0;
      #1;
      chk("async_state", state, 0);
      chk("async_tick", tick_1hz, 0);
      chk("async_clr", cnt_clr, 0);
      chk("async_led", led, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      goto(2); btn_start = 1'b1;
      goto(7); btn_start = 1'b0;
      for (int t = 8; t <= 19; t++) begin
         goto(t);
         chk("rst_run_state", state, (t >= 9) ? 1 : 0);
         chk("rst_run_tick", tick_1hz, int'(t == 18));
      end
      chk("rst_run_led", led, 1);

      // randomized button activity with occasional asynchronous resets
      hold_s = 0;
      hold_c = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (hold_s == 0) begin
            btn_start = ($urandom_range(0, 2) == 0);
            hold_s    = $urandom_range(1, 12);
         end else begin
            hold_s--;
         end
         if (hold_c == 0) begin
            btn_clear = ($urandom_range(0, 5) == 0);
            hold_c    = $urandom_range(1, 10);
         end else begin
            hold_c--;
         end
         if ($urandom_range(0, 999) == 0) begin
            #2 rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
